// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter.
// Frame on tx_out: start bit (0), data LSB first, optional even parity, stop bit (1).
// Optional feature macro: SERIAL_TX_PARITY_EN adds an even-parity bit between data and stop.
module serial_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cyc_cnt, w_cyc_cnt_nxt;
  logic [BitW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_out, w_out_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_cyc_term;
  logic              w_last_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity, w_parity_nxt;
`endif

  assign w_cyc_term = (r_cyc_cnt == CntLast);
  assign w_last_bit = (r_bit_cnt == BitLast);

  // Next-state, counters, shift register and registered-output next values.
  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_cnt_nxt = r_cyc_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_out_nxt     = r_out;
    w_done_nxt    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    // Every non-idle state holds its bit for CLKS_PER_BIT cycles.
    if (r_state != StIdle) begin
      w_cyc_cnt_nxt = w_cyc_term ? '0 : r_cyc_cnt + CntW'(1);
    end

    case (r_state)
      StIdle: begin
        w_out_nxt = 1'b1;
        if (tx_valid && r_ready) begin
          w_state_nxt   = StStart;
          w_shift_nxt   = tx_data;
          w_cyc_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_out_nxt     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          w_parity_nxt  = ^tx_data;
`endif
        end
      end
      StStart: begin
        if (w_cyc_term) begin
          w_state_nxt = StData;
          w_out_nxt   = r_shift[0];
          w_shift_nxt = r_shift >> 1;
        end
      end
      StData: begin
        if (w_cyc_term) begin
          if (w_last_bit) begin
            w_bit_cnt_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt   = StParity;
            w_out_nxt     = r_parity;
`else
            w_state_nxt   = StStop;
            w_out_nxt     = 1'b1;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
            w_out_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (w_cyc_term) begin
          w_state_nxt = StStop;
          w_out_nxt   = 1'b1;
        end
      end
`endif
      StStop: begin
        if (w_cyc_term) begin
          w_state_nxt = StIdle;
          w_out_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings fall back to an idle line.
        w_state_nxt   = StIdle;
        w_cyc_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
        w_out_nxt     = 1'b1;
      end
    endcase

    w_ready_nxt = (w_state_nxt == StIdle);
    w_busy_nxt  = (w_state_nxt != StIdle);
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_out     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cyc_cnt <= w_cyc_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_out     <= w_out_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  assign tx_out   = r_out;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: a main instance (8 data bits, 4 clocks/bit)
// and an edge instance (1 data bit, 1 clock/bit). Expected frames are hand-written
// bit strings, leftmost bit sent first.
module tb_serial_frame_tx;

  typedef struct {
    logic [15:0] seq;
    int          nb;
    int          cpb;
  } frame_t;

`ifdef SERIAL_TX_PARITY_EN
  localparam int          NB     = 11;
  localparam int          NBE    = 4;
  localparam logic [15:0] SEQ_A5 = 16'b01010010101;
  localparam logic [15:0] SEQ_07 = 16'b01110000011;
  localparam logic [15:0] SEQ_01 = 16'b01000000011;
  localparam logic [15:0] SEQ_FF = 16'b01111111101;
  localparam logic [15:0] SEQ_3C = 16'b00011110001;
  localparam logic [15:0] SEQ_E1 = 16'b0111;
`else
  localparam int          NB     = 10;
  localparam int          NBE    = 3;
  localparam logic [15:0] SEQ_A5 = 16'b0101001011;
  localparam logic [15:0] SEQ_07 = 16'b0111000001;
  localparam logic [15:0] SEQ_01 = 16'b0100000001;
  localparam logic [15:0] SEQ_FF = 16'b0111111111;
  localparam logic [15:0] SEQ_3C = 16'b0001111001;
  localparam logic [15:0] SEQ_E1 = 16'b011;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_out, tx_busy, tx_done;
  logic [0:0] e_data;
  logic       e_valid;
  logic       e_ready, e_out, e_busy, e_done;

  logic [1:0] m_valid, m_ready, m_out, m_busy, m_done;

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t q0[$];
  frame_t q1[$];

  assign m_valid = {e_valid, tx_valid};
  assign m_ready = {e_ready, tx_ready};
  assign m_out   = {e_out, tx_out};
  assign m_busy  = {e_busy, tx_busy};
  assign m_done  = {e_done, tx_done};

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut_edge (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (e_data),
    .tx_valid (e_valid),
    .tx_ready (e_ready),
    .tx_out   (e_out),
    .tx_busy  (e_busy),
    .tx_done  (e_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle line waveform for a frame, cycle 0 = first cycle after the handshake.
  function automatic logic [63:0] expand(input logic [15:0] seq, input int nb, input int cpb);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < cpb; c++) w[j*cpb+c] = seq[nb-1-j];
    end
    return w;
  endfunction

  task automatic push_exp(input int id, input logic [15:0] seq, input int nb, input int cpb);
    frame_t f;
    f.seq = seq;
    f.nb  = nb;
    f.cpb = cpb;
    if (id == 0) q0.push_back(f);
    else         q1.push_back(f);
  endtask

  // Monitor: a handshake seen at a negedge opens a frame; capture the line for the
  // expected frame length, then check the tx_done cycle that must follow directly.
  task automatic run_monitor(input int id);
    frame_t      e;
    logic [63:0] got, want;
    bit          aborted, busy_ok, have;
    int          len;
    forever begin
      @(negedge clk);
      while (!reset && m_valid[id] && m_ready[id]) begin
        have = 1'b0;
        if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          check($sformatf("unexpected_handshake_%0d", id), 1, 0);
          break;
        end
        want    = expand(e.seq, e.nb, e.cpb);
        len     = e.nb * e.cpb;
        got     = '0;
        aborted = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < len; k++) begin
          @(negedge clk);
          if (reset) begin aborted = 1'b1; break; end
          got[k] = m_out[id];
          if (!m_busy[id] || m_ready[id] || m_done[id]) busy_ok = 1'b0;
        end
        if (aborted) break;
        check($sformatf("frame_bits_%0d", id), got, want);
        check($sformatf("busy_during_frame_%0d", id), busy_ok, 1);
        @(negedge clk);
        if (reset) break;
        // {done, ready, busy, out} in the first idle cycle
        check($sformatf("done_cycle_%0d", id),
              {m_done[id], m_ready[id], m_busy[id], m_out[id]}, 4'b1101);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  task automatic wait_accept(input int id, output logic done_seen);
    bit ok;
    ok = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_ready[id]) begin
        ok = 1'b1;
        done_seen = m_done[id];
        break;
      end
    end
    check($sformatf("accept_in_time_%0d", id), ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_done[id]) begin ok = 1'b1; break; end
    end
    check($sformatf("done_in_time_%0d", id), ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    logic saw_done;
    bit   bad;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    e_valid  = 1'b0;
    e_data   = 1'b0;
    #2;
    check("reset_main", {tx_out, tx_ready, tx_busy, tx_done}, 4'b1100);
    check("reset_edge", {e_out, e_ready, e_busy, e_done}, 4'b1100);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single frame 0xA5; tx_data changes after the handshake.
    push_exp(0, SEQ_A5, NB, 4);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_done(0, 60);

    // 0x07: odd number of ones.
    push_exp(0, SEQ_07, NB, 4);
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    wait_done(0, 60);

    // Back-to-back 0x01 then 0xFF with tx_valid held.
    push_exp(0, SEQ_01, NB, 4);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    push_exp(0, SEQ_FF, NB, 4);
    tx_data  = 8'hFF;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    check("b2b_accept_on_done", saw_done, 1);
    wait_done(0, 60);

    // Mid-frame tx_valid pulse with new data must be ignored.
    push_exp(0, SEQ_3C, NB, 4);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    check("ignored_ready_low", tx_ready, 0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_done(0, 60);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_busy || !tx_ready) bad = 1'b1;
    end
    check("no_extra_frame", bad, 0);

    // Reset while the line is low in the middle of a frame.
    push_exp(0, SEQ_A5, NB, 4);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("line_low_before_reset", tx_out, 0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_midframe", {tx_out, tx_ready, tx_busy, tx_done}, 4'b1100);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_done || !tx_out || tx_busy) bad = 1'b1;
    end
    check("no_done_after_abort", bad, 0);

    // Fresh full frame after the aborted one.
    push_exp(0, SEQ_07, NB, 4);
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    wait_accept(0, saw_done);
    tx_valid = 1'b0;
    wait_done(0, 60);

    // Edge instance: one data bit, one clock per bit.
    push_exp(1, SEQ_E1, NBE, 1);
    e_data  = 1'b1;
    e_valid = 1'b1;
    wait_accept(1, saw_done);
    e_valid = 1'b0;
    e_data  = 1'b0;
    wait_done(1, 20);

    repeat (5) @(posedge clk);
    check("scoreboard_drained_main", q0.size(), 0);
    check("scoreboard_drained_edge", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
